// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - UART byte-stream to ALU frame controller
// Collects A, B, OP bytes, launches one TX byte per frame, resyncs on inter-byte timeout.
module uart_alu_sequencer #(
    parameter int NBIT_DATA      = 8,
    parameter int NBIT_OP        = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 rx_done_tick,
    input  logic [NBIT_DATA-1:0] rx_data,
    input  logic [NBIT_DATA-1:0] alu_result,
    input  logic                 tx_done_tick,
    output logic [NBIT_DATA-1:0] alu_a,
    output logic [NBIT_DATA-1:0] alu_b,
    output logic [NBIT_OP-1:0]   alu_op,
    output logic [NBIT_DATA-1:0] tx_data,
    output logic                 tx_start,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam bit            LP_TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int            CW         = LP_TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LP_CNT_MAX = CW'(LP_TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_GET_B,
        ST_GET_OP,
        ST_EXEC,
        ST_WAIT_TX
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NBIT_DATA-1:0] r_alu_a,    w_alu_a_nxt;
    logic [NBIT_DATA-1:0] r_alu_b,    w_alu_b_nxt;
    logic [NBIT_OP-1:0]   r_alu_op,   w_alu_op_nxt;
    logic [NBIT_DATA-1:0] r_tx_data,  w_tx_data_nxt;
    logic                 r_tx_start, w_tx_start_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 r_overrun,  w_overrun_nxt;
    logic [CW-1:0]        r_cnt,      w_cnt_nxt;

    logic w_in_frame;
    logic w_expire;

    // Only the mid-frame states are timed; a byte in the expiry cycle takes priority.
    assign w_in_frame = (r_state == ST_GET_B) || (r_state == ST_GET_OP);
    assign w_expire   = LP_TO_EN && w_in_frame && !rx_done_tick && (r_cnt == LP_CNT_MAX);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_GET_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_GET_A: begin
                if (rx_done_tick) w_state_nxt = ST_GET_B;
            end
            ST_GET_B: begin
                if (rx_done_tick)  w_state_nxt = ST_GET_OP;
                else if (w_expire) w_state_nxt = ST_GET_A;
            end
            ST_GET_OP: begin
                if (rx_done_tick)  w_state_nxt = ST_EXEC;
                else if (w_expire) w_state_nxt = ST_GET_A;
            end
            ST_EXEC: begin
                w_state_nxt = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done_tick) w_state_nxt = ST_GET_A;
            end
            default: begin
                w_state_nxt = ST_GET_A;
            end
        endcase
    end

    always_comb begin
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_alu_op_nxt    = r_alu_op;
        w_tx_data_nxt   = r_tx_data;
        w_tx_start_nxt  = 1'b0;
        w_busy_nxt      = r_busy;
        w_frame_err_nxt = w_expire;
        w_overrun_nxt   = 1'b0;
        w_cnt_nxt       = '0;
        case (r_state)
            ST_GET_A: begin
                if (rx_done_tick) w_alu_a_nxt = rx_data;
            end
            ST_GET_B: begin
                if (rx_done_tick) w_alu_b_nxt = rx_data;
            end
            ST_GET_OP: begin
                if (rx_done_tick) begin
                    w_alu_op_nxt = rx_data[NBIT_OP-1:0];
                    w_busy_nxt   = 1'b1;
                end
            end
            ST_EXEC: begin
                w_tx_data_nxt  = alu_result;
                w_tx_start_nxt = 1'b1;
                w_overrun_nxt  = rx_done_tick;
            end
            ST_WAIT_TX: begin
                w_overrun_nxt = rx_done_tick;
                if (tx_done_tick) w_busy_nxt = 1'b0;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
        // Counter is cleared by any accepted byte or by expiry, so it never wraps.
        if (LP_TO_EN && w_in_frame && !rx_done_tick && !w_expire) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_alu_op    <= w_alu_op_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_busy      <= w_busy_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb/tb_uart_alu_sequencer.sv - directed self-checking bench for uart_alu_sequencer
module tb_uart_alu_sequencer;

    logic       CLK;
    logic       RST_N;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic [7:0] alu_result;
    logic       tx_done_tick;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    uart_alu_sequencer #(
        .NBIT_DATA(8),
        .NBIT_OP(6),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .rx_done_tick(rx_done_tick),
        .rx_data(rx_data),
        .alu_result(alu_result),
        .tx_done_tick(tx_done_tick),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .busy(busy),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    // Model ALU: 8-bit add, carry dropped
    assign alu_result = alu_a + alu_b;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; strobe is sampled on the next posedge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge CLK);
        rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done_tick = 1'b1;
        @(negedge CLK);
        tx_done_tick = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp_res);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check_eq({tag, "_alu_a"}, alu_a, a);
        check_eq({tag, "_alu_b"}, alu_b, b);
        check_eq({tag, "_alu_op"}, alu_op, op & 8'h3F);
        check_eq({tag, "_busy_k1"}, busy, 1);
        check_eq({tag, "_txs_k1"}, tx_start, 0);
        @(negedge CLK);
        check_eq({tag, "_txs_k2"}, tx_start, 1);
        check_eq({tag, "_txd_k2"}, tx_data, exp_res);
        @(negedge CLK);
        check_eq({tag, "_txs_k3"}, tx_start, 0);
        check_eq({tag, "_busy_k3"}, busy, 1);
        pulse_tx_done();
        check_eq({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_err;
        int hits;
        int txs;

        RST_N        = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        tx_done_tick = 1'b0;
        repeat (3) @(negedge CLK);

        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_alu_b", alu_b, 0);
        check_eq("rst_alu_op", alu_op, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_tx_start", tx_start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_overrun", overrun, 0);

        RST_N = 1'b1;
        @(negedge CLK);

        // Stray tx_done outside WAIT_TX must be ignored
        pulse_tx_done();
        check_eq("idle_txdone_busy", busy, 0);

        run_frame("t1", 8'h05, 8'h03, 8'h20, 8'h08);

        // Timeout: A accepted, then silence; expiry visible 100 cycles after A's edge
        send_byte(8'h11);
        first_err = -1;
        hits = 0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge CLK);
            if (frame_err) begin
                hits++;
                if (first_err < 0) first_err = i;
            end
        end
        check_eq("t2_frame_err_cycle", first_err, 100);
        check_eq("t2_frame_err_width", hits, 1);
        check_eq("t2_alu_a_kept", alu_a, 8'h11);
        run_frame("t2", 8'h01, 8'h02, 8'h20, 8'h03);

        // Byte lands exactly on the expiry cycle and must win
        send_byte(8'h10);
        hits = 0;
        for (int i = 1; i <= 99; i++) begin
            @(negedge CLK);
            hits += int'(frame_err);
        end
        send_byte(8'h07);
        hits += int'(frame_err);
        send_byte(8'h20);
        hits += int'(frame_err);
        check_eq("t3_no_frame_err", hits, 0);
        check_eq("t3_alu_b", alu_b, 8'h07);
        check_eq("t3_busy", busy, 1);
        @(negedge CLK);
        check_eq("t3_txs", tx_start, 1);
        check_eq("t3_txd", tx_data, 8'h17);
        pulse_tx_done();
        check_eq("t3_busy_done", busy, 0);

        // Overrun during WAIT_TX
        send_byte(8'h40);
        send_byte(8'h02);
        send_byte(8'h20);
        @(negedge CLK);
        check_eq("t4_txs", tx_start, 1);
        check_eq("t4_txd", tx_data, 8'h42);
        send_byte(8'hAA);
        check_eq("t4_overrun", overrun, 1);
        check_eq("t4_alu_a_kept", alu_a, 8'h40);
        @(negedge CLK);
        check_eq("t4_overrun_width", overrun, 0);
        txs = 0;
        for (int i = 0; i < 5; i++) begin
            txs += int'(tx_start);
            @(negedge CLK);
        end
        check_eq("t4_no_second_txs", txs, 0);
        check_eq("t4_busy_hold", busy, 1);
        pulse_tx_done();
        check_eq("t4_busy_done", busy, 0);
        run_frame("t4b", 8'h02, 8'h02, 8'h20, 8'h04);

        // Reset while tx_start is high
        send_byte(8'h30);
        send_byte(8'h04);
        send_byte(8'h20);
        @(negedge CLK);
        check_eq("t5_txs_pre", tx_start, 1);
        RST_N = 1'b0;
        #1;
        check_eq("t5_txs", tx_start, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_alu_a", alu_a, 0);
        check_eq("t5_alu_b", alu_b, 0);
        check_eq("t5_alu_op", alu_op, 0);
        check_eq("t5_tx_data", tx_data, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        run_frame("t5b", 8'h09, 8'h06, 8'h20, 8'h0F);

        // Carry dropped by the 8-bit result
        run_frame("t6", 8'hFF, 8'h01, 8'h20, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
